// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) behind a valid/ready handshake,
// with optional two-bit zero tail that returns the trellis to state 00 at the end of each frame.
module conv_encoder_k3 #(
  parameter bit          ENABLE_TAIL = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sym,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] sym_cnt
);

  typedef enum logic [0:0] {ST_DATA, ST_TAIL} state_t;

  state_t     state, state_nxt;
  logic [1:0] s, s_nxt;
  logic       tail_cnt, tail_nxt;
  logic       valid_nxt, last_nxt;
  logic [1:0] sym_nxt;
  logic       slot_free_c;
  logic       out_acc_c;

  assign slot_free_c = !out_valid || out_ready;
  assign out_acc_c   = out_valid && out_ready;
  assign in_ready    = slot_free_c && (state == ST_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_DATA;
      s         <= 2'b00;
      tail_cnt  <= 1'b0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      tail_cnt  <= tail_nxt;
      out_valid <= valid_nxt;
      out_sym   <= sym_nxt;
      out_last  <= last_nxt;
    end
  end

  // Next-state and output-register load; the output register holds while stalled.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    tail_nxt  = tail_cnt;
    valid_nxt = out_valid;
    sym_nxt   = out_sym;
    last_nxt  = out_last;
    if (slot_free_c) begin
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end
    case (state)
      ST_DATA: begin
        if (in_valid && in_ready) begin
          sym_nxt   = {in_bit ^ s[0] ^ s[1], in_bit ^ s[1]};
          valid_nxt = 1'b1;
          s_nxt     = {s[0], in_bit};
          last_nxt  = 1'b0;
          if (in_last) begin
            if (ENABLE_TAIL) begin
              state_nxt = ST_TAIL;
              tail_nxt  = 1'b0;
            end else begin
              last_nxt = 1'b1;
              s_nxt    = 2'b00;
            end
          end
        end
      end
      ST_TAIL: begin
        if (slot_free_c) begin
          sym_nxt   = {s[0] ^ s[1], s[1]};
          valid_nxt = 1'b1;
          s_nxt     = {s[0], 1'b0};
          tail_nxt  = tail_cnt + 1'b1;
          last_nxt  = 1'b0;
          if (tail_cnt == 1'b1) begin
            last_nxt  = 1'b1;
            state_nxt = ST_DATA;
            tail_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = ST_DATA;
    endcase
  end

  // Statistics: symbols and frames accepted downstream, both wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_cnt   <= '0;
      frame_cnt <= '0;
    end else if (out_acc_c) begin
      sym_cnt <= sym_cnt + CNT_W'(1);
      if (out_last) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed bench for conv_encoder_k3: tail (dut_a) and no-tail (dut_b) instances share clock,
// reset and out_ready; accepted symbols are collected into queues and compared to hand-computed values.
module tb_conv_encoder_k3;

  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b1;

  logic             a_in_valid = 1'b0, a_in_bit = 1'b0, a_in_last = 1'b0;
  logic             a_in_ready, a_out_valid, a_out_last;
  logic [1:0]       a_out_sym;
  logic [CNT_W-1:0] a_frame_cnt, a_sym_cnt;

  logic             b_in_valid = 1'b0, b_in_bit = 1'b0, b_in_last = 1'b0;
  logic             b_in_ready, b_out_valid, b_out_last;
  logic [1:0]       b_out_sym;
  logic [CNT_W-1:0] b_frame_cnt, b_sym_cnt;

  always #5 clk = ~clk;

  conv_encoder_k3 #(.ENABLE_TAIL(1'b1), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_sym(a_out_sym),
    .out_last(a_out_last), .frame_cnt(a_frame_cnt), .sym_cnt(a_sym_cnt)
  );

  conv_encoder_k3 #(.ENABLE_TAIL(1'b0), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bit(b_in_bit),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_sym(b_out_sym),
    .out_last(b_out_last), .frame_cnt(b_frame_cnt), .sym_cnt(b_sym_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       sel = 1'b0;
  logic       stall = 1'b0;
  logic       acc = 1'b0;
  logic       tail_chk = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_obs = '0;

  logic [2:0] qa[$];
  logic [2:0] qb[$];
  int         qcyc[$];
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive out_ready at the falling edge, sample 1 ns later, wait for the next falling edge.
  task automatic tick();
    out_ready = stall ? ~out_ready : 1'b1;
    #1;
    if (prev_stall) chk("hold_while_stalled", 32'({a_out_valid, a_out_last, a_out_sym}), 32'(prev_obs));
    prev_stall = a_out_valid && !out_ready;
    prev_obs   = {1'b1, a_out_last, a_out_sym};
    if (tail_chk) begin
      if (a_out_valid && a_out_last) tail_chk = 1'b0;
      else chk("in_ready_during_tail", 32'(a_in_ready), 32'd0);
    end
    if (a_out_valid && out_ready) begin
      qa.push_back({a_out_last, a_out_sym});
      qcyc.push_back(cyc);
    end
    if (b_out_valid && out_ready) qb.push_back({b_out_last, b_out_sym});
    acc = sel ? (b_in_valid && b_in_ready) : (a_in_valid && a_in_ready);
    cyc++;
    @(negedge clk);
  endtask

  // Present bits LSB first; in_last on the final bit when with_last is set. in_valid left high.
  task automatic send_bits(input logic [7:0] bits, input int n, input logic with_last);
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        b_in_valid = 1'b1; b_in_bit = bits[i]; b_in_last = with_last && (i == n - 1);
      end else begin
        a_in_valid = 1'b1; a_in_bit = bits[i]; a_in_last = with_last && (i == n - 1);
      end
      acc = 1'b0;
      for (int g = 0; g < 50 && !acc; g++) tick();
      chk("bit_accepted", 32'(acc), 32'd1);
    end
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int g = 0; g < 60 && (sel ? qb.size() : qa.size()) < n; g++) tick();
    chk("symbol_count", 32'(sel ? qb.size() : qa.size()), 32'(n));
  endtask

  task automatic check_q(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (sel) chk(tag, (i < qb.size()) ? 32'(qb[i]) : 32'hDEAD, 32'(exp_q[i]));
      else     chk(tag, (i < qa.size()) ? 32'(qa[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_sym",   32'(a_out_sym),   32'd0);
    chk("rst_out_last",  32'(a_out_last),  32'd0);
    chk("rst_frame_cnt", 32'(a_frame_cnt), 32'd0);
    chk("rst_sym_cnt",   32'(a_sym_cnt),   32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);

    // Test 1: frame 1,0,1,1 with tail, no backpressure; {last,sym} per accepted symbol
    qa.delete(); qcyc.delete();
    send_bits(8'b0000_1101, 4, 1'b1);
    idle_inputs();
    drain(6);
    exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    check_q("t1_sym");
    chk("t1_frame_cnt", 32'(a_frame_cnt), 32'd1);
    chk("t1_sym_cnt",   32'(a_sym_cnt),   32'd6);

    // Test 2: same frame, out_ready toggling; symbols hold while stalled, in_ready low in the tail
    qa.delete(); qcyc.delete();
    stall = 1'b1;
    send_bits(8'b0000_1101, 4, 1'b1);
    idle_inputs();
    tail_chk = 1'b1;
    drain(6);
    stall = 1'b0;
    tick();
    check_q("t2_sym");
    chk("t2_tail_seen",  32'(tail_chk),    32'd0);
    chk("t2_frame_cnt", 32'(a_frame_cnt), 32'd2);
    chk("t2_sym_cnt",   32'(a_sym_cnt),   32'd12);

    // Test 3: back-to-back frames {1,1} and {0,1}, in_valid held high
    qa.delete(); qcyc.delete();
    send_bits(8'b0000_0011, 2, 1'b1);
    send_bits(8'b0000_0010, 2, 1'b1);
    idle_inputs();
    drain(8);
    exp_q = '{3'b011, 3'b001, 3'b001, 3'b111, 3'b000, 3'b011, 3'b010, 3'b111};
    check_q("t3_sym");
    chk("t3_no_bubble", (qcyc.size() == 8) ? 32'(qcyc[7] - qcyc[0]) : 32'hDEAD, 32'd7);
    chk("t3_frame_cnt", 32'(a_frame_cnt), 32'd4);
    chk("t3_sym_cnt",   32'(a_sym_cnt),   32'd20);

    // Test 4: no-tail instance, frame {1,1} then {1}; second frame starts from state 00
    sel = 1'b1;
    qb.delete();
    send_bits(8'b0000_0011, 2, 1'b1);
    send_bits(8'b0000_0001, 1, 1'b1);
    idle_inputs();
    drain(3);
    exp_q = '{3'b011, 3'b101, 3'b111};
    check_q("t4_sym");
    chk("t4_frame_cnt", 32'(b_frame_cnt), 32'd2);
    chk("t4_sym_cnt",   32'(b_sym_cnt),   32'd3);
    sel = 1'b0;

    // Test 5: reset mid-frame with a symbol pending, then a single-bit frame
    send_bits(8'b0000_0001, 2, 1'b0);
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    prev_stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_out_valid", 32'(a_out_valid), 32'd0);
    chk("t5_frame_cnt", 32'(a_frame_cnt), 32'd0);
    chk("t5_sym_cnt",   32'(a_sym_cnt),   32'd0);
    qa.delete(); qcyc.delete();
    send_bits(8'b0000_0001, 1, 1'b1);
    idle_inputs();
    drain(3);
    exp_q = '{3'b011, 3'b010, 3'b111};
    check_q("t5_sym");
    chk("t5_frame_cnt_after", 32'(a_frame_cnt), 32'd1);
    chk("t5_sym_cnt_after",   32'(a_sym_cnt),   32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
